// File: rtl/phase_a_pkg.sv
// Shared constants and the requester-ID type for the phase_a arbitration slice.
package phase_a_pkg;

    localparam int unsigned OP_WIDTH         = 3072;
    localparam int unsigned PA_PAD_LSB       = 78;
    localparam int unsigned DEF_MAX_INFLIGHT = 4;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/tag_fifo.sv
// Small synchronous FIFO holding requester tags; a pop frees space for a same-cycle push.
module tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/phase_a_arb.sv
// Round-robin arbiter sharing one in-order phase_a datapath between two requesters,
// routing each result back to its originator via a tag FIFO.
module phase_a_arb
    import phase_a_pkg::*;
#(
    parameter int unsigned WIDTH        = OP_WIDTH,
    parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req0_valid,
    input  logic [WIDTH-1:0]                req0_a,
    output logic                            req0_ready,
    input  logic                            req1_valid,
    input  logic [WIDTH-1:0]                req1_a,
    output logic                            req1_ready,
    output logic                            pa_en,
    output logic [WIDTH-1:0]                pa_a,
    input  logic                            pa_en_out,
    input  logic [WIDTH-1:0]                pa_new_a,
    output logic                            rsp0_valid,
    output logic                            rsp1_valid,
    output logic [WIDTH-1:0]                rsp_data,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            err
);

    req_id_t    last_grant;
    req_id_t    grant_id;
    req_id_t    head_id;
    logic [0:0] head_raw;
    logic       fifo_full;
    logic       fifo_empty;
    logic       accept;
    logic       retire;
    logic       spurious;
    logic       can_accept;

    assign retire     = pa_en_out && !fifo_empty;
    assign spurious   = pa_en_out && fifo_empty;
    assign can_accept = !fifo_full || retire;
    assign head_id    = req_id_t'(head_raw);

    // Requester 0 wins contention unless it was the last one granted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && can_accept) begin
            if (req0_valid && (!req1_valid || last_grant == REQ1)) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    assign accept   = req0_ready || req1_ready;
    assign grant_id = req1_ready ? REQ1 : REQ0;

    tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (1)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (grant_id),
        .pop       (retire),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ1;
            pa_en      <= 1'b0;
            pa_a       <= '0;
        end else begin
            pa_en <= accept;
            if (accept) begin
                last_grant <= grant_id;
                pa_a       <= req1_ready ? req1_a : req0_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            err        <= 1'b0;
            inflight   <= '0;
        end else begin
            rsp0_valid <= retire && (head_id == REQ0);
            rsp1_valid <= retire && (head_id == REQ1);
            if (retire) rsp_data <= pa_new_a;
            if (spurious) err <= 1'b1;
            case ({accept, retire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_a_arb.sv
// Randomized scoreboard bench for phase_a_arb with a behavioural phase_a model.
module tb_phase_a_arb;

    localparam int unsigned W    = 3072;
    localparam int unsigned MAXI = 4;

    logic           clk;
    logic           rst_n;
    logic           req0_valid;
    logic [W-1:0]   req0_a;
    logic           req0_ready;
    logic           req1_valid;
    logic [W-1:0]   req1_a;
    logic           req1_ready;
    logic           pa_en;
    logic [W-1:0]   pa_a;
    logic           pa_en_out;
    logic [W-1:0]   pa_new_a;
    logic           rsp0_valid;
    logic           rsp1_valid;
    logic [W-1:0]   rsp_data;
    logic [2:0]     inflight;
    logic           err;

    phase_a_arb #(
        .WIDTH        (W),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_ready (req1_ready),
        .pa_en      (pa_en),
        .pa_a       (pa_a),
        .pa_en_out  (pa_en_out),
        .pa_new_a   (pa_new_a),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .inflight   (inflight),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        logic [W-1:0] data;
        int unsigned due;
    } item_t;

    item_t       issue_q[$];
    item_t       rsp_q[$];
    item_t       pend[$];
    int unsigned ids[$];

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned lat = 8;
    int unsigned last_win = 1;
    bit          model_err = 0;
    bit          use_fix = 0;
    logic [W-1:0] fix_op;
    logic [W-1:0] fix_res;

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h want 0x%h (low 64 bits) cycle %0d",
                     name, act[63:0], exp[63:0], cyc);
        end
    endtask

    // One clock of stimulus; the reference model decides grants and schedules results.
    task automatic step(input logic v0, input logic v1, input logic spur);
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        bit ret, room, e0, e1;
        item_t it;
        a0 = use_fix ? fix_op : rand_word();
        a1 = rand_word();
        req0_valid = v0;
        req1_valid = v1;
        req0_a = a0;
        req1_a = a1;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            it = pend.pop_front();
            pa_en_out = 1'b1;
            pa_new_a = it.data;
        end else begin
            pa_en_out = spur;
            pa_new_a = rand_word();
        end
        @(negedge clk);
        ret  = pa_en_out && ids.size() > 0;
        room = ids.size() < MAXI || ret;
        e0 = room && v0 && (!v1 || last_win == 1);
        e1 = room && v1 && (!v0 || last_win == 0);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("inflight", inflight, ids.size());
        chk("err", err, model_err);
        if (pa_en_out && ids.size() == 0) model_err = 1;
        if (ret) begin
            it.id = ids.pop_front();
            it.data = pa_new_a;
            it.due = cyc + 1;
            rsp_q.push_back(it);
        end
        if (e0 || e1) begin
            it.id = e1 ? 1 : 0;
            it.data = e1 ? a1 : a0;
            it.due = cyc + 1;
            issue_q.push_back(it);
            ids.push_back(it.id);
            last_win = it.id;
            it.data = use_fix ? fix_res : rand_word();
            it.due = cyc + 1 + lat;
            pend.push_back(it);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((pend.size() > 0 || ids.size() > 0) && n < 200) begin
            step(0, 0, 0);
            n++;
        end
        step(0, 0, 0);
        step(0, 0, 0);
        chk("drain_in_time", n < 200, 1);
        chk("issue_q_empty", issue_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
    endtask

    task automatic do_reset(input int unsigned n);
        rst_n = 1'b0;
        issue_q.delete();
        rsp_q.delete();
        pend.delete();
        ids.delete();
        model_err = 0;
        last_win = 1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pa_en_out = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_pa_en", pa_en, 0);
            chk("rst_pa_a", pa_a, 0);
            chk("rst_rsp0", rsp0_valid, 0);
            chk("rst_rsp1", rsp1_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_inflight", inflight, 0);
            chk("rst_err", err, 0);
            @(posedge clk);
            cyc++;
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: consumes expected pa_en issues and responses as the DUT presents them.
    always begin
        item_t it;
        @(posedge clk);
        #2;
        if (rst_n) begin
            while (issue_q.size() > 0 && issue_q[0].due < cyc) begin
                it = issue_q.pop_front();
                chk("pa_en_missing", 0, 1);
            end
            while (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
                it = rsp_q.pop_front();
                chk("rsp_missing", 0, 1);
            end
            if (pa_en) begin
                if (issue_q.size() > 0 && issue_q[0].due == cyc) begin
                    it = issue_q.pop_front();
                    chk("pa_a", pa_a, it.data);
                end else begin
                    chk("pa_en_unexpected", pa_en, 0);
                end
            end
            if (rsp0_valid || rsp1_valid) begin
                if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                    it = rsp_q.pop_front();
                    chk("rsp_both", rsp0_valid && rsp1_valid, 0);
                    chk("rsp_id", rsp1_valid, it.id);
                    chk("rsp_data", rsp_data, it.data);
                end else begin
                    chk("rsp_unexpected", 1, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0;
        req1_a = '0;
        pa_en_out = 1'b0;
        pa_new_a = '0;
        @(posedge clk);
        cyc++;
        #1;
        do_reset(2);

        // Spurious result with nothing outstanding, then reset clears err.
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);
        do_reset(1);
        step(0, 0, 0);

        // Single op with fixed operand/result, latency 8.
        fix_op = '0;
        fix_op[31:0] = 32'h5537b809;
        fix_res = '0;
        fix_res[31:0] = 32'hd284de3c;
        use_fix = 1;
        lat = 8;
        step(1, 0, 0);
        use_fix = 0;
        drain();

        // Contention from reset: grants alternate starting with req0.
        do_reset(1);
        lat = 6;
        repeat (4) step(1, 1, 0);
        drain();

        // Full datapath with long latency; retire cycle admits a new op.
        lat = 20;
        repeat (30) step(1, 1, 0);
        drain();

        // Back-to-back single requester, short latency.
        lat = 3;
        repeat (10) step(0, 1, 0);
        drain();

        // Reset with three ops outstanding, then a fresh req1 op.
        lat = 20;
        repeat (3) step(1, 1, 0);
        repeat (2) step(0, 0, 0);
        do_reset(2);
        lat = 5;
        step(0, 1, 0);
        drain();

        // Random traffic segments with varying latency.
        for (int s = 0; s < 8; s++) begin
            lat = $urandom_range(1, 12);
            repeat (40) step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60, 0);
            drain();
        end
        step(0, 0, 1);
        repeat (2) step(0, 0, 0);
        do_reset(1);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
